// File: rtl/nn_input_loader_if.sv
// Pixel-stream and NeuralNetwork handshake bundle for nn_input_loader.
// The slave modport is the loader's view; master is the surrounding pipeline.
interface nn_input_loader_if #(
    parameter int numInputs = 784,
    parameter int dataWidth = 16,
    parameter int pixWidth  = 8
);
    logic [pixWidth-1:0]            pix_in;
    logic                           pix_valid;
    logic                           pix_sof;
    logic                           pix_last;
    logic                           pix_ready;
    logic [numInputs*dataWidth-1:0] NNin;
    logic                           NNvalid;
    logic                           NNoutValid;
    logic                           busy;
    logic                           frame_err;
    logic                           timeout_err;
    logic [15:0]                    frame_count;

    modport master (
        output pix_in, pix_valid, pix_sof, pix_last, NNoutValid,
        input  pix_ready, NNin, NNvalid, busy, frame_err, timeout_err, frame_count
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof, pix_last, NNoutValid,
        output pix_ready, NNin, NNvalid, busy, frame_err, timeout_err, frame_count
    );
endinterface

// File: rtl/nn_input_loader.sv
// Assembles a numInputs-pixel frame into the Q8.8 NNin vector; NNvalid the cycle after the last accept.
// pix_ready drops for HOLD and BUSY; frame_err is registered, timeout_err is flagged in the expiring BUSY cycle.
module nn_input_loader #(
    parameter int numInputs     = 784,
    parameter int dataWidth     = 16,
    parameter int dataFracWidth = 8,
    parameter int pixWidth      = 8,
    parameter int timeoutCycles = 65535
) (
    input  logic            clk,
    input  logic            reset,
    nn_input_loader_if.slave bus
);
    localparam int IDX_W = (numInputs > 1) ? $clog2(numInputs) : 1;
    localparam int CNT_W = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    localparam int SHIFT = dataFracWidth - pixWidth;
    localparam bit TO_EN = (timeoutCycles != 0);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(numInputs - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(timeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 frame_err_q, frame_err_d;
    logic [pixWidth-1:0]  pix_q [numInputs];

    logic                 accept;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_slot;
    logic                 timeout_hit;

    assign accept = bus.pix_valid && (state_q == ST_FILL);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        frame_err_d   = 1'b0;
        wr_en         = 1'b0;
        wr_slot       = '0;
        timeout_hit   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    // SOF always restarts at slot 0; an interrupted partial frame is an error.
                    wr_slot = bus.pix_sof ? '0 : idx_q;
                    if (bus.pix_sof && (idx_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                    if (wr_slot == LAST_SLOT) begin
                        state_d = ST_HOLD;
                        idx_d   = '0;
                        if (!bus.pix_last) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (bus.pix_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = wr_slot + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                state_d = ST_BUSY;
                cnt_d   = '0;
            end
            ST_BUSY: begin
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (bus.NNoutValid) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_FILL;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_FILL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Only the raw pixel is stored; the Q8.8 expansion is pure wiring.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < numInputs; k++) begin
                pix_q[k] <= '0;
            end
        end else if (wr_en) begin
            pix_q[wr_slot] <= bus.pix_in;
        end
    end

    for (genvar g = 0; g < numInputs; g++) begin : g_nnin
        assign bus.NNin[g*dataWidth +: dataWidth] = dataWidth'(pix_q[g]) << SHIFT;
    end

    assign bus.pix_ready   = (state_q == ST_FILL);
    assign bus.NNvalid     = (state_q == ST_HOLD);
    assign bus.busy        = (state_q != ST_FILL);
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_hit;
    assign bus.frame_count = frame_count_q;

endmodule
